// File: rtl/dm_hart_ctrl_if.sv
// dm_hart_ctrl_if: DMI request/response channel and Core debug port group of the Debug Module.
// Signal suffixes are from the controller's point of view.
interface dm_hart_ctrl_if #(
  parameter int ABITS = 7
);
  logic             dmi_req_valid_i;
  logic             dmi_req_ready_o;
  logic [ABITS-1:0] dmi_addr_i;
  logic [1:0]       dmi_op_i;
  logic [31:0]      dmi_wdata_i;
  logic             dmi_resp_valid_o;
  logic             dmi_resp_ready_i;
  logic [31:0]      dmi_resp_data_o;
  logic             dmi_resp_err_o;
  logic             dm_halt_req_o;
  logic             dm_halt_ack_i;
  logic             dm_resume_ack_i;
  logic             dm_ebreak_i;
  logic             dm_step_exec_i;
  logic             dm_reg_rd_wr_en_o;
  logic             dm_reg_rd_wr_o;
  logic [15:0]      dm_reg_rd_wr_address_o;
  logic [31:0]      dm_reg_wr_data_o;
  logic [31:0]      dm_reg_rd_data_i;
  modport slave (
    input  dmi_req_valid_i, dmi_addr_i, dmi_op_i, dmi_wdata_i, dmi_resp_ready_i,
           dm_halt_ack_i, dm_resume_ack_i, dm_ebreak_i, dm_step_exec_i, dm_reg_rd_data_i,
    output dmi_req_ready_o, dmi_resp_valid_o, dmi_resp_data_o, dmi_resp_err_o,
           dm_halt_req_o, dm_reg_rd_wr_en_o, dm_reg_rd_wr_o, dm_reg_rd_wr_address_o, dm_reg_wr_data_o
  );
  modport master (
    output dmi_req_valid_i, dmi_addr_i, dmi_op_i, dmi_wdata_i, dmi_resp_ready_i,
           dm_halt_ack_i, dm_resume_ack_i, dm_ebreak_i, dm_step_exec_i, dm_reg_rd_data_i,
    input  dmi_req_ready_o, dmi_resp_valid_o, dmi_resp_data_o, dmi_resp_err_o,
           dm_halt_req_o, dm_reg_rd_wr_en_o, dm_reg_rd_wr_o, dm_reg_rd_wr_address_o, dm_reg_wr_data_o
  );
endinterface

// File: rtl/dm_hart_ctrl.sv
// dm_hart_ctrl: DM register decode, hart halt/resume control and abstract register access.
module dm_hart_ctrl #(
  parameter int ABITS        = 7,
  parameter int HALT_TIMEOUT = 1024
) (
  input logic           clk_i,
  input logic           reset_i,
  dm_hart_ctrl_if.slave bus
);
  localparam int CW = $clog2(HALT_TIMEOUT + 1);
  localparam logic [ABITS-1:0] A_DATA0 = ABITS'('h04);
  localparam logic [ABITS-1:0] A_DMCTL = ABITS'('h10);
  localparam logic [ABITS-1:0] A_DMSTAT = ABITS'('h11);
  localparam logic [ABITS-1:0] A_ACS = ABITS'('h16);
  localparam logic [ABITS-1:0] A_CMD = ABITS'('h17);
  typedef enum logic [2:0] {RUNNING, HALTING, HALTED, ACCESS, RESUMING} state_e;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      data0_q, data0_d, resp_data_q, resp_data_d, rdata, wd;
  logic [2:0]       cmderr_q, cmderr_d;
  logic [15:0]      regno_q, regno_d;
  logic [ABITS-1:0] addr;
  logic dmactive_q, dmactive_d, haltreq_q, haltreq_d, resumeack_q, resumeack_d;
  logic xfer_q, xfer_d, rd_wr_q, rd_wr_d;
  logic resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic acc, rd, wr, act_wr, busy, halted, running, mapped;
  logic halt_wr, resume_wr, busy_wr, cmd_wr, cmd_ok;
  assign addr      = bus.dmi_addr_i;
  assign wd        = bus.dmi_wdata_i;
  assign acc       = bus.dmi_req_valid_i && !resp_valid_q;
  assign rd        = acc && bus.dmi_op_i == 2'd1;
  assign wr        = acc && bus.dmi_op_i == 2'd2;
  assign act_wr    = wr && dmactive_q;
  assign busy      = state_q == ACCESS;
  assign halted    = state_q == HALTED || busy;
  assign running   = state_q == RUNNING || state_q == HALTING;
  assign halt_wr   = wr && addr == A_DMCTL && wd[0] && wd[31];
  // haltreq wins over a resumereq written in the same access
  assign resume_wr = wr && addr == A_DMCTL && wd[0] && wd[30] && !wd[31];
  assign busy_wr   = act_wr && busy && (addr inside {A_DATA0, A_ACS, A_CMD});
  assign cmd_wr    = act_wr && !busy && addr == A_CMD && cmderr_q == 3'd0;
  assign cmd_ok    = cmd_wr && state_q == HALTED && wd[31:24] == 8'd0 && wd[22:20] == 3'd2;
  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    case (addr)
      A_DATA0:  rdata = data0_q;
      A_DMCTL:  rdata = {haltreq_q, 30'd0, dmactive_q};
      A_DMSTAT: rdata = {14'd0, {2{resumeack_q}}, 4'd0, {2{running}}, {2{halted}}, 4'd0, 4'd2};
      A_ACS:    rdata = {19'd0, busy, 1'b0, cmderr_q, 8'd0};
      A_CMD:    rdata = '0;
      default:  mapped = 1'b0;
    endcase
  end
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data0_d      = data0_q;
    cmderr_d     = cmderr_q;
    dmactive_d   = dmactive_q;
    haltreq_d    = haltreq_q;
    resumeack_d  = resumeack_q;
    xfer_d       = xfer_q;
    rd_wr_d      = rd_wr_q;
    regno_d      = regno_q;
    resp_valid_d = acc || (resp_valid_q && !bus.dmi_resp_ready_i);
    resp_data_d  = acc ? (rd ? rdata : '0) : resp_data_q;
    resp_err_d   = acc ? (rd || wr) && !mapped : resp_err_q;
    if (wr && addr == A_DMCTL) begin
      dmactive_d = wd[0];
      haltreq_d  = wd[0] && wd[31];
    end
    if (busy_wr && cmderr_q == 3'd0) cmderr_d = 3'd1;
    if (act_wr && !busy && addr == A_DATA0) data0_d = wd;
    if (act_wr && !busy && addr == A_ACS) cmderr_d = cmderr_q & ~wd[10:8];
    if (cmd_wr) cmderr_d = state_q != HALTED ? 3'd4 : cmd_ok ? 3'd0 : 3'd2;
    if (cmd_ok) begin
      xfer_d  = wd[17];
      rd_wr_d = wd[16];
      regno_d = wd[15:0];
    end
    case (state_q)
      RUNNING: begin
        state_d = bus.dm_ebreak_i ? HALTED : halt_wr ? HALTING : RUNNING;
        cnt_d   = '0;
      end
      HALTING: begin
        cnt_d   = cnt_q == CW'(HALT_TIMEOUT) ? cnt_q : cnt_q + CW'(1);
        state_d = (bus.dm_halt_ack_i || bus.dm_ebreak_i) ? HALTED :
                  cnt_d == CW'(HALT_TIMEOUT) ? RUNNING : HALTING;
      end
      HALTED: begin
        state_d     = resume_wr ? RESUMING : cmd_ok ? ACCESS : HALTED;
        resumeack_d = resumeack_q && !resume_wr;
      end
      ACCESS: begin
        state_d = HALTED;
        if (xfer_q && !rd_wr_q) data0_d = bus.dm_reg_rd_data_i;
      end
      RESUMING: begin
        state_d     = (bus.dm_ebreak_i || bus.dm_step_exec_i) ? HALTED :
                      bus.dm_resume_ack_i ? RUNNING : RESUMING;
        resumeack_d = resumeack_q || bus.dm_resume_ack_i || bus.dm_step_exec_i;
      end
      default: state_d = RUNNING;
    endcase
    if (!dmactive_d) state_d = RUNNING;
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= RUNNING;
      cnt_q        <= '0;
      data0_q      <= '0;
      cmderr_q     <= '0;
      dmactive_q   <= 1'b0;
      haltreq_q    <= 1'b0;
      resumeack_q  <= 1'b0;
      xfer_q       <= 1'b0;
      rd_wr_q      <= 1'b0;
      regno_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data0_q      <= data0_d;
      cmderr_q     <= cmderr_d;
      dmactive_q   <= dmactive_d;
      haltreq_q    <= haltreq_d;
      resumeack_q  <= resumeack_d;
      xfer_q       <= xfer_d;
      rd_wr_q      <= rd_wr_d;
      regno_q      <= regno_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end
  assign bus.dmi_req_ready_o        = !resp_valid_q;
  assign bus.dmi_resp_valid_o       = resp_valid_q;
  assign bus.dmi_resp_data_o        = resp_data_q;
  assign bus.dmi_resp_err_o         = resp_err_q;
  assign bus.dm_halt_req_o          = state_q == HALTING || halted;
  assign bus.dm_reg_rd_wr_en_o      = busy && xfer_q;
  assign bus.dm_reg_rd_wr_o         = rd_wr_q;
  assign bus.dm_reg_rd_wr_address_o = regno_q;
  assign bus.dm_reg_wr_data_o       = data0_q;
endmodule

// File: tb/tb_dm_hart_ctrl.sv
// tb_dm_hart_ctrl: directed DMI/Core vectors against dm_hart_ctrl with hand-computed expectations.
module tb_dm_hart_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vec = 0;
  int errs = 0;
  int strobes = 0;
  logic [31:0] d;
  logic e;
  dm_hart_ctrl_if #(.ABITS(7)) bus();
  dm_hart_ctrl #(.ABITS(7), .HALT_TIMEOUT(1024)) dut (.clk_i(clk), .reset_i(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.dm_reg_rd_wr_en_o) strobes++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic dmi_req(input logic [1:0] op, input logic [6:0] a, input logic [31:0] w);
    @(negedge clk);
    bus.dmi_req_valid_i = 1'b1;
    bus.dmi_op_i = op;
    bus.dmi_addr_i = a;
    bus.dmi_wdata_i = w;
    @(posedge clk);
    #1;
    bus.dmi_req_valid_i = 1'b0;
    bus.dmi_op_i = 2'd0;
  endtask
  task automatic dmi_resp(output logic [31:0] rd, output logic er);
    chk("resp_valid", {31'd0, bus.dmi_resp_valid_o}, 32'd1);
    rd = bus.dmi_resp_data_o;
    er = bus.dmi_resp_err_o;
    bus.dmi_resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.dmi_resp_ready_i = 1'b0;
  endtask
  task automatic rd_reg(input string tag, input logic [6:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic er;
    dmi_req(2'd1, a, 32'd0);
    dmi_resp(r, er);
    chk(tag, r, exp);
  endtask
  task automatic wr_reg(input logic [6:0] a, input logic [31:0] w);
    logic [31:0] r;
    logic er;
    dmi_req(2'd2, a, w);
    dmi_resp(r, er);
  endtask
  task automatic pulse(input int k);
    @(negedge clk);
    bus.dm_halt_ack_i = k == 0;
    bus.dm_resume_ack_i = k == 1;
    bus.dm_ebreak_i = k == 2;
    bus.dm_step_exec_i = k == 3;
    @(negedge clk);
    bus.dm_halt_ack_i = 1'b0;
    bus.dm_resume_ack_i = 1'b0;
    bus.dm_ebreak_i = 1'b0;
    bus.dm_step_exec_i = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.dmi_req_valid_i = 1'b0;
    bus.dmi_addr_i = '0;
    bus.dmi_op_i = 2'd0;
    bus.dmi_wdata_i = '0;
    bus.dmi_resp_ready_i = 1'b0;
    bus.dm_halt_ack_i = 1'b0;
    bus.dm_resume_ack_i = 1'b0;
    bus.dm_ebreak_i = 1'b0;
    bus.dm_step_exec_i = 1'b0;
    bus.dm_reg_rd_data_i = 32'h12345678;
    repeat (2) @(negedge clk);
    chk("rst_halt_req", {31'd0, bus.dm_halt_req_o}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.dmi_resp_valid_o}, 32'd0);
    chk("rst_strobe", {31'd0, bus.dm_reg_rd_wr_en_o}, 32'd0);
    chk("rst_resp_data", bus.dmi_resp_data_o, 32'd0);
    chk("rst_addr", {16'd0, bus.dm_reg_rd_wr_address_o}, 32'd0);
    chk("rst_wdata", bus.dm_reg_wr_data_o, 32'd0);
    rst_n = 1'b1;
    dmi_req(2'd1, 7'h11, 32'd0);
    dmi_resp(d, e);
    chk("dmstatus_reset", d, 32'h00000C02);
    chk("dmstatus_err", {31'd0, e}, 32'd0);
    dmi_req(2'd1, 7'h05, 32'd0);
    dmi_resp(d, e);
    chk("unmapped_data", d, 32'd0);
    chk("unmapped_err", {31'd0, e}, 32'd1);
    dmi_req(2'd2, 7'h10, 32'h80000001);
    chk("halting_req", {31'd0, bus.dm_halt_req_o}, 32'd1);
    dmi_resp(d, e);
    repeat (5) @(negedge clk);
    pulse(0);
    chk("halted_req", {31'd0, bus.dm_halt_req_o}, 32'd1);
    rd_reg("dmstatus_halted", 7'h11, 32'h00000302);
    rd_reg("dmcontrol_rb", 7'h10, 32'h80000001);
    wr_reg(7'h04, 32'hDEADBEEF);
    dmi_req(2'd2, 7'h17, 32'h00231005);
    chk("wr_strobe", {31'd0, bus.dm_reg_rd_wr_en_o}, 32'd1);
    chk("wr_rd_wr", {31'd0, bus.dm_reg_rd_wr_o}, 32'd1);
    chk("wr_addr", {16'd0, bus.dm_reg_rd_wr_address_o}, 32'h1005);
    chk("wr_wdata", bus.dm_reg_wr_data_o, 32'hDEADBEEF);
    dmi_resp(d, e);
    chk("wr_strobe_end", {31'd0, bus.dm_reg_rd_wr_en_o}, 32'd0);
    chk("wr_strobe_cnt", strobes, 32'd1);
    rd_reg("acs_idle", 7'h16, 32'd0);
    dmi_req(2'd2, 7'h17, 32'h00221002);
    chk("rd_strobe", {31'd0, bus.dm_reg_rd_wr_en_o}, 32'd1);
    chk("rd_rd_wr", {31'd0, bus.dm_reg_rd_wr_o}, 32'd0);
    chk("rd_addr", {16'd0, bus.dm_reg_rd_wr_address_o}, 32'h1002);
    dmi_resp(d, e);
    rd_reg("data0_captured", 7'h04, 32'h12345678);
    wr_reg(7'h17, 32'h00331002);
    rd_reg("acs_cmderr2", 7'h16, 32'h00000200);
    wr_reg(7'h17, 32'h00231005);
    rd_reg("acs_sticky", 7'h16, 32'h00000200);
    chk("no_strobe_err", strobes, 32'd2);
    wr_reg(7'h16, 32'h00000700);
    rd_reg("acs_cleared", 7'h16, 32'd0);
    wr_reg(7'h10, 32'hC0000001);
    rd_reg("halt_wins", 7'h11, 32'h00000302);
    dmi_req(2'd2, 7'h10, 32'h40000001);
    chk("resuming_req", {31'd0, bus.dm_halt_req_o}, 32'd0);
    dmi_resp(d, e);
    rd_reg("dmstatus_resuming", 7'h11, 32'h00000002);
    repeat (3) @(negedge clk);
    pulse(1);
    rd_reg("dmstatus_resumed", 7'h11, 32'h00030C02);
    pulse(0);
    rd_reg("stray_halt_ack", 7'h11, 32'h00030C02);
    wr_reg(7'h17, 32'h00231005);
    rd_reg("acs_cmderr4", 7'h16, 32'h00000400);
    chk("no_strobe_run", strobes, 32'd2);
    wr_reg(7'h16, 32'h00000400);
    rd_reg("acs_w1c", 7'h16, 32'd0);
    pulse(2);
    chk("ebreak_req", {31'd0, bus.dm_halt_req_o}, 32'd1);
    rd_reg("dmstatus_ebreak", 7'h11, 32'h00030302);
    wr_reg(7'h10, 32'h40000001);
    rd_reg("ack_cleared", 7'h11, 32'h00000002);
    pulse(3);
    rd_reg("dmstatus_step", 7'h11, 32'h00030302);
    wr_reg(7'h10, 32'h40000001);
    pulse(1);
    dmi_req(2'd2, 7'h10, 32'h80000001);
    dmi_resp(d, e);
    repeat (1000) @(negedge clk);
    chk("timeout_wait", {31'd0, bus.dm_halt_req_o}, 32'd1);
    repeat (30) @(negedge clk);
    chk("timeout_drop", {31'd0, bus.dm_halt_req_o}, 32'd0);
    rd_reg("dmstatus_timeout", 7'h11, 32'h00030C02);
    wr_reg(7'h10, 32'h00000000);
    wr_reg(7'h04, 32'h00000055);
    rd_reg("inactive_data0", 7'h04, 32'h12345678);
    rd_reg("inactive_dmctl", 7'h10, 32'd0);
    wr_reg(7'h10, 32'h00000001);
    pulse(2);
    dmi_req(2'd2, 7'h17, 32'h00221002);
    chk("mid_strobe", {31'd0, bus.dm_reg_rd_wr_en_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_strobe_drop", {31'd0, bus.dm_reg_rd_wr_en_o}, 32'd0);
    chk("rst_req_drop", {31'd0, bus.dm_halt_req_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_reg("rst_data0", 7'h04, 32'd0);
    rd_reg("rst_dmstatus", 7'h11, 32'h00000C02);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
